// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the 64x8 RAM burst controller.
package ram_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_LEN_W  = DEF_ADDR_W + 1;
    localparam int unsigned DEPTH      = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StDrain,
        StFin
    } state_e;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry read-return buffer: captures RAM output beats and presents them in arrival order.
module ram_rd_skid
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop && (cnt_q != 2'd0);
    // A full buffer can still take a beat when the head leaves in the same cycle.
    assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign occ  = cnt_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst command front-end for a single-port RAM with registered read output.
// Define BURST_WRAP_EN to let bursts wrap past the top address instead of rejecting them.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              reject_q;
    logic              in_flight_q;
    logic              done_q;
    logic              err_q;

    logic              wr_fire;
    logic              rd_issue;
    logic              rd_pop;
    logic              overrun;
    logic              ram_active;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;

`ifdef BURST_WRAP_EN
    assign overrun = 1'b0;
`else
    localparam logic [LEN_W:0] LIMIT = (LEN_W + 1)'(2 ** ADDR_W);
    logic [LEN_W:0] end_sum;
    assign end_sum = (LEN_W + 1)'(cmd_addr) + (LEN_W + 1)'(cmd_len);
    assign overrun = end_sum > LIMIT;
`endif

    assign cmd_ready  = (state_q == StIdle);
    assign wr_ready   = (state_q == StWr);
    assign wr_fire    = wr_ready && wr_valid;
    assign rd_valid   = (occ != 2'd0);
    assign rd_pop     = rd_valid && rd_ready;
    assign rd_data    = head;
    assign ram_active = (state_q == StWr) || (state_q == StRd);

    // Crediting the same-cycle pop keeps one issue per cycle with only two buffer slots.
    assign rd_issue = (state_q == StRd) &&
                      (({1'b0, occ} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, rd_pop}));

    assign ram_we   = wr_fire;
    assign ram_data = wr_data;
    assign ram_addr = ram_active ? addr_q : last_addr_q;
    assign done     = done_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            reject_q    <= 1'b0;
            in_flight_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_flight_q <= rd_issue;
            if (ram_active) begin
                last_addr_q <= addr_q;
            end
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        remaining_q <= cmd_len;
                        reject_q    <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q <= StFin;
                        end else if (overrun) begin
                            reject_q <= 1'b1;
                            state_q  <= StFin;
                        end else begin
                            state_q <= cmd_write ? StWr : StRd;
                        end
                    end
                end
                StWr: begin
                    if (wr_fire) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= StFin;
                        end
                    end
                end
                StRd: begin
                    if (rd_issue) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!in_flight_q && (occ == 2'd0)) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    err_q   <= reject_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    ram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data (ram_q),
        .pop       (rd_pop),
        .occ       (occ),
        .head      (head)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a RAM model and a transaction-level reference.
module tb_ram_burst_ctrl;
    import ram_ctrl_pkg::*;

`ifdef BURST_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [5:0] cmd_addr;
    logic [6:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       done, err;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    int n_done  = 0;
    int done_cyc = -1;
    int last_err = 0;
    int cyc = 0;
    int acc, nd, nw;

    logic [3:0] rdy_pat;
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] ram [DEPTH];
    bit         ram_loaded = 1'b0;
    bit         exp_err;
    int         exp_wa[$];
    logic [7:0] exp_wd[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wdat[$];
    int         pop_cyc[$];
    logic [7:0] pop_dat[$];
    bit         crdy_hist [int];

    ram_burst_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 64x8 RAM: write on we, registered read of the presented address.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i) ^ 8'hC0;
            ram_loaded <= 1'b1;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_data;
            ram_q <= ram[ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: what a command must do, from start address, length and wrap policy alone.
    task automatic model_cmd(input bit w, input int a, input int l, output int nacc);
        bit rej;
        int ad;
        rej     = (l != 0) && !WRAP && (a + l > DEPTH);
        exp_err = rej;
        nacc    = (l == 0 || rej) ? 0 : l;
        for (int i = 0; i < nacc; i++) begin
            ad = (a + i) % DEPTH;
            if (w) begin
                exp_wa.push_back(ad);
                exp_wd.push_back(wdat[i]);
                ref_mem[ad] = wdat[i];
            end else begin
                exp_rd.push_back(ref_mem[ad]);
            end
        end
    endtask

    task automatic monitor();
        crdy_hist[cyc] = cmd_ready;
        if (ram_we) begin
            chk("ram_we expected", int'(exp_wa.size() > 0), 1);
            if (exp_wa.size() > 0) begin
                chk("ram_addr", ram_addr, exp_wa.pop_front());
                chk("ram_data", ram_data, exp_wd.pop_front());
            end
            n_we++;
        end
        if (rd_valid) chk("rd_valid expected", int'(exp_rd.size() > 0), 1);
        if (rd_valid && rd_ready) begin
            if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
            pop_cyc.push_back(cyc);
            pop_dat.push_back(rd_data);
        end
        if (done) begin
            chk("err at done", err, exp_err);
            chk("writes pending at done", exp_wa.size(), 0);
            chk("reads pending at done", exp_rd.size(), 0);
            n_done++;
            done_cyc = cyc;
            last_err = err;
        end else begin
            chk("err without done", err, 0);
        end
    endtask

    // Called at a negedge with inputs set; checks mid-cycle, returns at the next negedge.
    task automatic step();
        rd_ready = rdy_pat[cyc[1:0]];
        #2;
        if (!rst) monitor();
        @(negedge clk);
    endtask

    task automatic do_cmd(input bit w, input int a, input int l, input bit wait_fin,
                          output int acc_cyc);
        int g, idx, nacc, start;
        model_cmd(w, a, l, nacc);
        start     = n_done;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = 6'(a);
        cmd_len   = 7'(l);
        wr_valid  = w;
        wr_data   = (wdat.size() > 0) ? wdat[0] : 8'h00;
        g = 0;
        while (!cmd_ready && g < 50) begin
            step();
            g++;
        end
        chk("cmd accepted", cmd_ready, 1);
        acc_cyc = cyc;
        step();
        cmd_valid = 1'b0;
        if (w) begin
            idx = 0;
            g   = 0;
            while (idx < nacc && g < 100) begin
                wr_data  = wdat[idx];
                wr_valid = 1'b1;
                if (wr_ready) idx++;
                step();
                g++;
            end
            chk("write beats", idx, nacc);
        end
        if (wait_fin) begin
            g = 0;
            while (n_done == start && g < 300) begin
                step();
                g++;
            end
            chk("done seen", n_done, start + 1);
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1; rdy_pat = 4'hF;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i) ^ 8'hC0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset wr_ready", wr_ready, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset ram_we", ram_we, 0);
        @(negedge clk);

        // Write 3 bytes at 4.
        wdat = '{8'hA1, 8'hB2, 8'hC3};
        nd = n_done; nw = n_we;
        do_cmd(1'b1, 4, 3, 1'b1, acc);
        step(); step();
        chk("t1 write count", n_we - nw, 3);
        chk("t1 single done", n_done, nd + 1);
        chk("t1 done cycle", done_cyc, acc + 5);

        // Read them back at full rate.
        pop_cyc.delete(); pop_dat.delete();
        do_cmd(1'b0, 4, 3, 1'b1, acc);
        chk("t2 beats", pop_dat.size(), 3);
        if (pop_dat.size() == 3) begin
            chk("t2 byte0", pop_dat[0], 8'hA1);
            chk("t2 byte1", pop_dat[1], 8'hB2);
            chk("t2 byte2", pop_dat[2], 8'hC3);
            chk("t2 first beat cycle", pop_cyc[0], acc + 3);
            chk("t2 last beat cycle", pop_cyc[2], acc + 5);
        end

        // Read 8 with consumer pattern 1,0,0,1.
        rdy_pat = 4'b1001;
        pop_cyc.delete(); pop_dat.delete();
        do_cmd(1'b0, 8, 8, 1'b1, acc);
        chk("t3 beats", pop_dat.size(), 8);
        if (pop_dat.size() == 8) begin
            chk("t3 first byte", pop_dat[0], 8'hC8);
            chk("t3 last byte", pop_dat[7], 8'hCF);
        end
        rdy_pat = 4'hF;

        // Burst ending exactly at the top is legal in both builds.
        wdat = '{8'h60, 8'h61, 8'h62, 8'h63};
        nw = n_we;
        do_cmd(1'b1, 60, 4, 1'b1, acc);
        chk("t4 fit writes", n_we - nw, 4);
        chk("t4 fit err", last_err, 0);

        // Crossing the top: wraps or is rejected.
        wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        nw = n_we;
        do_cmd(1'b1, 62, 4, 1'b1, acc);
`ifdef BURST_WRAP_EN
        chk("t4 wrap writes", n_we - nw, 4);
        chk("t4 wrap err", last_err, 0);
        pop_dat.delete(); pop_cyc.delete();
        do_cmd(1'b0, 62, 4, 1'b1, acc);
        chk("t4 wrap readback beats", pop_dat.size(), 4);
        if (pop_dat.size() == 4) begin
            chk("t4 wrap byte at 0", pop_dat[2], 8'h33);
            chk("t4 wrap byte at 1", pop_dat[3], 8'h44);
        end
`else
        chk("t4 overrun writes", n_we - nw, 0);
        chk("t4 overrun err", last_err, 1);
        chk("t4 overrun done cycle", done_cyc, acc + 2);
`endif

        // Zero length.
        nw = n_we;
        do_cmd(1'b1, 10, 0, 1'b1, acc);
        chk("t5 writes", n_we - nw, 0);
        chk("t5 done cycle", done_cyc, acc + 2);
        chk("t5 err", last_err, 0);
        chk("t5 cmd_ready in FIN", crdy_hist[acc + 1], 0);
        chk("t5 cmd_ready back", crdy_hist[acc + 2], 1);

        // Reset in the middle of a stalled read.
        rdy_pat = 4'h0;
        do_cmd(1'b0, 0, 8, 1'b0, acc);
        repeat (5) step();
        chk("t6 rd_valid before reset", rd_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6 rd_valid in reset", rd_valid, 0);
        chk("t6 ram_we in reset", ram_we, 0);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        @(negedge clk);
        rst = 1'b0;
        rdy_pat = 4'hF;
        #1;
        chk("t6 cmd_ready after reset", cmd_ready, 1);
        pop_dat.delete(); pop_cyc.delete();
        do_cmd(1'b0, 4, 3, 1'b1, acc);
        chk("t6 clean beats", pop_dat.size(), 3);
        if (pop_dat.size() == 3) begin
            chk("t6 clean byte0", pop_dat[0], 8'hA1);
            chk("t6 clean byte2", pop_dat[2], 8'hC3);
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
